// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column scan sequencer for a 5x4 keypad.
// Drives one column low at a time, samples rows after a settle delay,
// debounces a candidate press, hands the key code to the consumer through
// a one-entry valid/ready holding register, then waits for release.
module keypad_scan_ctrl #(
  parameter int SETTLE_CYC   = 16,
  parameter int DEBOUNCE_CNT = 100000,
  parameter int RELEASE_CNT  = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_drv,
  input  logic [4:0] row_in,
  output logic [4:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_drop,
  output logic       busy
);

  localparam int SW = (SETTLE_CYC   < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int DW = (DEBOUNCE_CNT < 1) ? 1 : $clog2(DEBOUNCE_CNT + 1);
  localparam int RW = (RELEASE_CNT  < 1) ? 1 : $clog2(RELEASE_CNT + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t          state_q,     state_d;
  logic [1:0]      col_idx_q,   col_idx_d;
  logic [3:0]      col_drv_q,   col_drv_d;
  logic [SW-1:0]   set_cnt_q,   set_cnt_d;
  logic [DW-1:0]   deb_cnt_q,   deb_cnt_d;
  logic [RW-1:0]   rel_cnt_q,   rel_cnt_d;
  logic [4:0]      row_pat_q,   row_pat_d;
  logic [2:0]      cap_row_q,   cap_row_d;
  logic [4:0]      key_code_q,  key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_drop_q,  key_drop_d;
  logic            busy_q,      busy_d;
  logic            emit;
  logic [4:0]      emit_code;

  // Lowest-numbered active-low row wins when several rows are pressed.
  function automatic logic [2:0] low_row(input logic [4:0] rows);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (!rows[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Next-state computation for the scan FSM, counters and holding register.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    set_cnt_d   = set_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    row_pat_d   = row_pat_q;
    cap_row_d   = cap_row_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    key_drop_d  = 1'b0;
    emit        = 1'b0;
    emit_code   = {cap_row_q, 2'b00} + {3'b000, col_idx_q};

    case (state_q)
      ST_SCAN: begin
        if (set_cnt_q == SW'(SETTLE_CYC)) begin
          set_cnt_d = '0;
          if (row_in == 5'b11111) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            row_pat_d = row_in;
            cap_row_d = low_row(row_in);
            deb_cnt_d = '0;
            state_d   = ST_DEBOUNCE;
          end
        end else begin
          set_cnt_d = set_cnt_q + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_in != row_pat_q) begin
          set_cnt_d = '0;
          state_d   = ST_SCAN;
        end else if (deb_cnt_q == DW'(DEBOUNCE_CNT - 1)) begin
          emit      = 1'b1;
          rel_cnt_d = '0;
          state_d   = ST_HELD;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      ST_HELD: begin
        // The release count is checked before the current sample, so the
        // next column appears RELEASE_CNT+1 cycles after rows go high.
        if (rel_cnt_q == RW'(RELEASE_CNT)) begin
          col_idx_d = col_idx_q + 2'd1;
          set_cnt_d = '0;
          state_d   = ST_SCAN;
        end else if (row_in == 5'b11111) begin
          rel_cnt_d = rel_cnt_q + RW'(1);
        end else begin
          rel_cnt_d = '0;
        end
      end
      default: begin
        state_d   = ST_SCAN;
        col_idx_d = 2'd0;
        set_cnt_d = '0;
      end
    endcase

    // Consumer handshake first, then a same-cycle emit may reload.
    if (key_valid_q && key_ready) key_valid_d = 1'b0;
    if (emit) begin
      if (!key_valid_q || key_ready) begin
        key_code_d  = emit_code;
        key_valid_d = 1'b1;
      end else begin
        key_drop_d  = 1'b1;
      end
    end

    col_drv_d = ~(4'b0001 << col_idx_d);
    busy_d    = (state_d != ST_SCAN);
  end

  // State register; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      col_drv_q   <= 4'b1110;
      set_cnt_q   <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      row_pat_q   <= 5'b11111;
      cap_row_q   <= 3'd0;
      key_code_q  <= 5'd0;
      key_valid_q <= 1'b0;
      key_drop_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_drv_q   <= col_drv_d;
      set_cnt_q   <= set_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      row_pat_q   <= row_pat_d;
      cap_row_q   <= cap_row_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_drop_q  <= key_drop_d;
      busy_q      <= busy_d;
    end
  end

  assign col_drv   = col_drv_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_drop  = key_drop_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed testbench for keypad_scan_ctrl with SETTLE/DEBOUNCE/RELEASE = 4/8/8.
// A small keypad model pulls a row low when its key is pressed and the
// key's column is being driven; force_high models a bounce.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_drv;
  logic [4:0]  row_in;
  logic [4:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_drop;
  logic        busy;

  logic [19:0] keys;
  logic        force_high;
  int          n_checks;
  int          n_errors;

  keypad_scan_ctrl #(
    .SETTLE_CYC  (4),
    .DEBOUNCE_CNT(8),
    .RELEASE_CNT (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_drv  (col_drv),
    .row_in   (row_in),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_drop (key_drop),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    row_in = 5'b11111;
    if (!force_high) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4 + c] && !col_drv[c]) row_in[r] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_col;
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    keys       = '0;
    force_high = 1'b0;
    key_ready  = 1'b1;

    // Reset state
    tick(3);
    chk("rst_col_drv", 32'(col_drv), 32'h0e);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_key_drop", 32'(key_drop), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // No key: each column for 5 cycles, cycles 0..39
    for (int i = 0; i < 40; i++) begin
      exp_col = ~(4'b0001 << ((i / 5) % 4));
      chk("idle_col_drv", 32'(col_drv), 32'(exp_col));
      chk("idle_key_valid", 32'(key_valid), 32'h0);
      tick(1);
    end

    // Row 2 / col 1, t0 = 45, valid at 58
    keys[9] = 1'b1;
    tick(5);
    chk("k9_t0_col", 32'(col_drv), 32'h0d);
    tick(12);
    chk("k9_pre_valid", 32'(key_valid), 32'h0);
    chk("k9_busy_deb", 32'(busy), 32'h1);
    tick(1);
    chk("k9_valid", 32'(key_valid), 32'h1);
    chk("k9_code", 32'(key_code), 32'd9);
    tick(1);
    chk("k9_valid_clear", 32'(key_valid), 32'h0);
    keys = '0;
    tick(8);
    chk("k9_rel_col_hold", 32'(col_drv), 32'h0d);
    chk("k9_rel_busy", 32'(busy), 32'h1);
    tick(1);
    chk("k9_rel_next_col", 32'(col_drv), 32'h0b);
    chk("k9_rel_idle", 32'(busy), 32'h0);

    // Row 4 / col 3 with a bounce at debounce sample 5
    keys[19] = 1'b1;
    tick(5);
    chk("k19_t0_col", 32'(col_drv), 32'h07);
    tick(9);
    chk("k19_busy_deb", 32'(busy), 32'h1);
    force_high = 1'b1;
    tick(1);
    force_high = 1'b0;
    chk("k19_bounce_scan", 32'(busy), 32'h0);
    chk("k19_bounce_novalid", 32'(key_valid), 32'h0);
    chk("k19_bounce_col", 32'(col_drv), 32'h07);
    tick(12);
    chk("k19_pre_valid", 32'(key_valid), 32'h0);
    chk("k19_busy_redeb", 32'(busy), 32'h1);
    tick(1);
    chk("k19_valid", 32'(key_valid), 32'h1);
    chk("k19_code", 32'(key_code), 32'd19);
    tick(1);
    chk("k19_valid_clear", 32'(key_valid), 32'h0);
    keys      = '0;
    key_ready = 1'b0;

    // Consumer stalled: code 0 kept, code 5 dropped
    tick(9);
    chk("k0_t0_col", 32'(col_drv), 32'h0e);
    keys[0] = 1'b1;
    tick(13);
    chk("k0_valid", 32'(key_valid), 32'h1);
    chk("k0_code", 32'(key_code), 32'd0);
    keys = '0;
    tick(9);
    chk("k5_t0_col", 32'(col_drv), 32'h0d);
    keys[5] = 1'b1;
    tick(12);
    chk("k5_pre_drop", 32'(key_drop), 32'h0);
    tick(1);
    chk("k5_drop", 32'(key_drop), 32'h1);
    chk("k5_valid_kept", 32'(key_valid), 32'h1);
    chk("k5_code_kept", 32'(key_code), 32'd0);
    tick(1);
    chk("k5_drop_pulse", 32'(key_drop), 32'h0);
    chk("k5_code_stable", 32'(key_code), 32'd0);
    keys      = '0;
    key_ready = 1'b1;
    tick(1);
    chk("k5_consumed", 32'(key_valid), 32'h0);

    // Rows 0 and 3 on col 2, then reset while HELD
    tick(8);
    chk("k2_t0_col", 32'(col_drv), 32'h0b);
    keys[2]   = 1'b1;
    keys[14]  = 1'b1;
    key_ready = 1'b0;
    tick(13);
    chk("k2_valid", 32'(key_valid), 32'h1);
    chk("k2_code", 32'(key_code), 32'd2);
    tick(4);
    chk("k2_held_busy", 32'(busy), 32'h1);
    chk("k2_held_col", 32'(col_drv), 32'h0b);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_col", 32'(col_drv), 32'h0e);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_code", 32'(key_code), 32'h0);
    tick(2);
    keys  = '0;
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_col", 32'(col_drv), 32'h0e);
    chk("post_rst_valid", 32'(key_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan sequencer for the 5x4 calculator keypad. It drives the columns one at a time and samples the rows after a settle delay. A candidate press is debounced, a key code is issued through a one-entry valid/ready holding register, and release is awaited before scanning resumes. It sits between the keypad pins and the calculator input decoder, and it replaces free-running periodic sampling of the raw row/column lines.

## Interface
- SETTLE_CYC, 16: cycles a column is driven before its rows are sampled (≥1).
- DEBOUNCE_CNT, 100000: consecutive identical samples required to accept a press (≥1).
- RELEASE_CNT, 100000: consecutive all-high samples required to accept a release (≥1).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- col_drv  out  4  column drive, active-low one-hot.
- row_in  in  5  keypad rows, active-low, externally pulled up; treated as already synchronised.
- key_code  out  5  row*4 + col, range 0..19.
- key_valid  out  1  key_code holds an unconsumed key.
- key_ready  in  1  consumer accepts key_code when key_valid && key_ready.
- key_drop  out  1  one-cycle pulse: a debounced key was discarded because the holding register was full.
- busy  out  1  high in DEBOUNCE or HELD.

## Operation
- Reset values:
  - col_drv=4'b1110 (column 0 driven).
  - key_code=0, key_valid=0, key_drop=0, busy=0.
  - state=SCAN, col_idx=0, all counters 0.
- col_drv = ~(4'b0001 << col_idx) in every state.
- SCAN: settle counter runs 0..SETTLE_CYC. In the cycle where it equals SETTLE_CYC, row_in is sampled.
  - row_in == 5'b11111: col_idx increments (3 wraps to 0), counter clears, stay in SCAN.
  - Otherwise: latch row_pat = row_in and cap_row = lowest index with a 0 bit (row 0 has priority), then go to DEBOUNCE. col_idx is held.
- DEBOUNCE: row_in is sampled every cycle.
  - row_in == row_pat: deb counter increments.
  - Any mismatch: return to SCAN at the same col_idx, settle counter cleared.
  - When the count of matching samples reaches DEBOUNCE_CNT: emit code {cap_row*4 + col_idx} and go to HELD.
- HELD: col_idx is held, and row_in is watched for release.
  - row_in == 5'b11111: rel counter increments.
  - Any low row: rel counter clears.
  - When rel reaches RELEASE_CNT: col_idx increments (with wrap) and the block returns to SCAN with the settle counter cleared.
- Emit rules:
  - key_valid == 0, or key_valid && key_ready in the same cycle: key_code is loaded and key_valid is set.
  - Otherwise the new code is dropped, key_drop pulses, and the held code is kept.
- Handshake:
  - key_valid clears on the cycle after key_valid && key_ready, unless a simultaneous emit reloads it.
  - key_code is stable while key_valid is high.
- Multiple keys:
  - Keys in other columns are not detected while HELD.
  - Two rows low in the same column report the lower row index. The pattern must stay identical through debounce.
- Arithmetic:
  - key_code = {cap_row, 2'b00} + col_idx, 5 bits, no overflow (max 19).
  - Counters are sized to clog2(max parameter + 1).

## Timing
- With no key pressed, each column is driven for SETTLE_CYC+1 cycles. A full scan takes 4*(SETTLE_CYC+1) cycles.
- Press stable from before column drive at cycle t0:
  - Sample at t0+SETTLE_CYC.
  - DEBOUNCE occupies t0+SETTLE_CYC+1 .. t0+SETTLE_CYC+DEBOUNCE_CNT.
  - key_valid rises at t0+SETTLE_CYC+DEBOUNCE_CNT+1.
- Release: the next column is driven RELEASE_CNT+1 cycles after row_in first returns to all-high, provided it stays high.
- key_drop is asserted in the same cycle key_valid would have loaded.
- rst_n low at any time, including mid-DEBOUNCE or mid-HELD: all state returns to reset values immediately, and any pending key is lost.

## Test plan
- Params 4/8/8 used for all scenarios below.
- No key, 40 cycles after reset: col_drv cycles 1110,1101,1011,0111, each for 5 cycles, then repeats. key_valid stays 0.
- Row 2 held low only while col 1 is driven, key_ready=1: key_code=9, with key_valid high exactly one cycle at t0+13 (t0 = first col 1 drive). After release, col 2 is driven 9 cycles later.
- Row 4, col 3 pressed, bounce (row goes high) at debounce sample 5, then stable: no emit on the bounce, re-settle on col 3, key_code=19 emitted later.
- key_ready=0, two successive presses code 0 and then code 5: key_code stays 0 with key_valid=1, and key_drop pulses once on the second emit.
- Press rows 0 and 3 together on col 2: key_code=2. Assert rst_n=0 mid-HELD: col_drv=1110 and key_valid=0 immediately.
